// File: rtl/uart_rx_monitor.sv
// UART receiver: 2-FF sync, mid-bit sampling, show-ahead FIFO; push 1 cycle after last stop sample, drop+overflow when full.
// Optional UART_RX_MONITOR_BREAK_EN: all-zero frames with a framing error raise break_det instead of being queued.
module uart_rx_monitor #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 rxd,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 clr_status,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          err_cnt
`ifdef UART_RX_MONITOR_BREAK_EN
  ,
  output logic                 break_det
`endif
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bidx_q, bidx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 rxd_s1_q, rxd_s_q, rxd_prev_q;
  logic                 fall, frame_done, done_ferr;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic [EW-1:0]        head;
  logic                 empty, full, pop, brk, push_req, acc, drop, err_inc;
  logic [15:0]          frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic                 overflow_q, overflow_d, break_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rxd_s1_q   <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s_q    <= rxd_s1_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  assign fall = ~rxd_s_q & rxd_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bidx_d     = bidx_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    done_ferr  = ferr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d  = '0;
          bidx_d = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d  = '0;
          sh_d   = {rxd_s_q, sh_q[DATA_BITS-1:1]};
          bidx_d = bidx_q + 4'd1;
          if (bidx_q == 4'(DATA_BITS - 1)) begin
            bidx_d  = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          perr_d  = ((^sh_q) ^ rxd_s_q) != (PARITY == 1);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          if (!rxd_s_q) ferr_d = 1'b1;
          if (bidx_q == 4'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            done_ferr  = ferr_q | ~rxd_s_q;
            state_d    = S_IDLE;
          end else begin
            bidx_d = bidx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_MONITOR_BREAK_EN
  assign brk = frame_done & (sh_q == '0) & done_ferr;
`else
  assign brk = 1'b0;
`endif

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign m_valid  = ~empty;
  assign pop      = m_valid & m_ready;
  assign push_req = frame_done & ~brk;
  assign acc      = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign err_inc  = (acc & (perr_q | done_ferr)) | brk;

  always_ff @(posedge CLOCK_50) begin
    if (acc) mem_q[wr_q[AW-1:0]] <= {sh_q, perr_q, done_ferr};
  end

  assign head   = mem_q[rd_q[AW-1:0]];
  assign m_data = m_valid ? head[EW-1:2] : '0;
  assign m_perr = m_valid & head[1];
  assign m_ferr = m_valid & head[0];

  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(acc);
    err_cnt_d   = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    overflow_d  = overflow_q | drop;
    if (clr_status) begin
      frame_cnt_d = 16'(acc);
      err_cnt_d   = 16'(err_inc);
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_q        <= '0;
      rd_q        <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      if (acc) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      overflow_q  <= overflow_d;
      break_q     <= brk;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`ifdef UART_RX_MONITOR_BREAK_EN
  assign break_det = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor at 17 clocks/bit, 8E1: scoreboard queue filled by stimulus, drained by a pop monitor.
module tb_uart_rx_monitor;
  localparam int DIV = 17;  // 1 MHz / 57600 truncated

  typedef struct packed {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        m_ready = 1'b1;
  logic        clr_status = 1'b0;
  logic        m_valid, m_perr, m_ferr, busy, overflow;
  logic [7:0]  m_data;
  logic [15:0] frame_cnt, err_cnt;
`ifdef UART_RX_MONITOR_BREAK_EN
  logic        break_det;
  int          brk_pulses = 0;
`endif

  exp_t q[$];
  exp_t got_e, want_e;
  int   nvec = 0;
  int   nmis = 0;

  uart_rx_monitor #(
    .CLK_HZ(1000000), .BAUD(57600), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .rxd(rxd),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr),
    .busy(busy), .overflow(overflow), .clr_status(clr_status),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`ifdef UART_RX_MONITOR_BREAK_EN
    , .break_det(break_det)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      nvec++;
      got_e = {m_data, m_perr, m_ferr};
      if (q.size() == 0) begin
        nmis++;
        $display("FAIL pop_unexpected: got data=%02h perr=%0b ferr=%0b, required no output",
                 m_data, m_perr, m_ferr);
      end else begin
        want_e = q.pop_front();
        if (got_e !== want_e) begin
          nmis++;
          $display("FAIL pop_compare: got data=%02h perr=%0b ferr=%0b, required data=%02h perr=%0b ferr=%0b",
                   got_e.d, got_e.perr, got_e.ferr, want_e.d, want_e.perr, want_e.ferr);
        end
      end
    end
  end

`ifdef UART_RX_MONITOR_BREAK_EN
  always @(negedge clk) if (break_det === 1'b1) brk_pulses++;
`endif

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(DIV);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
    rxd = 1'b1;
    tick(DIV);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    tick(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_flags", {m_perr, m_ferr}, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    tick(2 * DIV);

    // 0x55: four ones, even parity bit 0
    q.push_back(exp_t'({8'h55, 2'b00}));
    send(8'h55, 1'b0, 1'b1);
    check("b55_frame_cnt", frame_cnt, 1);
    check("b55_err_cnt", err_cnt, 0);

    // 0xA3 with wrong parity bit 1
    q.push_back(exp_t'({8'hA3, 2'b10}));
    send(8'hA3, 1'b1, 1'b1);
    check("par_err_cnt", err_cnt, 1);
    check("par_frame_cnt", frame_cnt, 2);

    // 0x5A with stop held low one bit, then line back high
    q.push_back(exp_t'({8'h5A, 2'b01}));
    send(8'h5A, 1'b0, 1'b0);
    tick(3 * DIV);
    check("ferr_frame_cnt", frame_cnt, 3);
    check("ferr_err_cnt", err_cnt, 2);
    check("ferr_busy_idle", busy, 0);

    // short low glitch enters START, then aborts without a push
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(2);
    check("glitch_busy_start", busy, 1);
    tick(DIV);
    check("glitch_busy_idle", busy, 0);
    check("glitch_frame_cnt", frame_cnt, 3);

    // line low for 12 bit times: all-zero data, parity 0 ok, stop 0
`ifndef UART_RX_MONITOR_BREAK_EN
    q.push_back(exp_t'({8'h00, 2'b01}));
`endif
    rxd = 1'b0;
    tick(12 * DIV);
    rxd = 1'b1;
    tick(2 * DIV);
    check("brk_busy", busy, 0);
    check("brk_err_cnt", err_cnt, 3);
`ifdef UART_RX_MONITOR_BREAK_EN
    check("brk_frame_cnt", frame_cnt, 3);
    check("brk_pulses", brk_pulses, 1);
`else
    check("brk_frame_cnt", frame_cnt, 4);
`endif

    // reset in the middle of the data bits of 0x3C
    b = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    rxd = 1'b1;
    tick(3);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    tick(DIV);
    q.push_back(exp_t'({8'h81, 2'b00}));
    send(8'h81, 1'b0, 1'b1);
    check("b81_frame_cnt", frame_cnt, 1);

    // overflow: 17 frames into a 16-deep FIFO with no consumer
    pulse_clr();
    check("clr1_frame_cnt", frame_cnt, 0);
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'(i);
      if (i < 16) q.push_back(exp_t'({b, 2'b00}));
      send(b, ^b, 1'b1);
    end
    check("ovf_flag", overflow, 1);
    check("ovf_frame_cnt", frame_cnt, 16);
    check("ovf_err_cnt", err_cnt, 0);
    check("ovf_m_valid", m_valid, 1);
    check("ovf_head", m_data, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    check("ovf_drain_left", q.size(), 0);
    tick(2);
    check("ovf_empty", m_valid, 0);
    check("ovf_still_set", overflow, 1);
    pulse_clr();
    check("clr2_overflow", overflow, 0);
    check("clr2_frame_cnt", frame_cnt, 0);
    check("clr2_err_cnt", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Parametrised, synthesisable successor to the bench-level UART TX activity print: decodes a UART line (normally UART_TXD of fpgaTop) into bytes with error flags and buffers them in a FIFO.
- Generalised in baud, data width, parity and stop bits; adds error detection, overflow tracking and frame counters.
- Instantiated in the testbench for self-checking, or on-board to loop UART output onto LEDR/HEX.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer truncation), HALF = DIV/2.
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, entries; power of two, >= 2.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- rxd  in  1  UART line; idle high; asynchronous to CLOCK_50.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer pops the head when m_valid & m_ready.
- m_data  out  DATA_BITS  head data.
- m_perr  out  1  head parity error.
- m_ferr  out  1  head framing error.
- busy  out  1  frame in progress (state != IDLE).
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- clr_status  in  1  synchronous clear of overflow and both counters.
- frame_cnt  out  16  frames pushed; wraps at 0xFFFF to 0.
- err_cnt  out  16  frames pushed with perr | ferr; saturates at 0xFFFF.

Behaviour:
- Reset (async on RESET_N = 0):
  - state IDLE, FIFO empty.
  - m_valid/m_perr/m_ferr/busy/overflow = 0; m_data = 0; counters = 0.
  - Two-flop synchroniser and previous-sample register preset to 1.
  - A frame interrupted by reset is discarded.
- Input: rxd passes through a 2-FF synchroniser to rxd_s. A start is a falling edge: rxd_s = 0 with previous rxd_s = 1.
- Bit counter cnt counts clock cycles within a bit.
- FSM:
  - IDLE: on falling edge -> START, cnt = 0.
  - START: at cnt == HALF-1 sample rxd_s.
    - 0 -> DATA, cnt = 0, bit index = 0.
    - 1 -> IDLE: glitch; no push, no counter change.
  - DATA: at cnt == DIV-1 sample into shift register (LSB first), cnt = 0. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: sample at cnt == DIV-1; perr = (XOR of data ^ sample) != (PARITY == 1). -> STOP.
  - STOP: sample each stop bit at cnt == DIV-1. Any stop sample of 0 sets ferr. After the last stop bit: push {data, perr, ferr}, -> IDLE.
  - A new frame needs a fresh falling edge, so a line held low after a framing error never retriggers.
- Push happens on the clock edge of the last stop sample; m_valid asserts the next cycle when the FIFO was empty. The FIFO is show-ahead.
- Push with FIFO full and no pop in the same cycle: frame dropped, overflow <= 1, frame_cnt/err_cnt unchanged.
- Push and pop in the same cycle while full: both succeed, occupancy unchanged.
- Pop with FIFO empty is ignored.
- frame_cnt/err_cnt increment on accepted pushes only.
- clr_status together with an accepted push in the same cycle: clear wins for overflow; counters load 1 (err_cnt 1 only if errored).

Optional Feature:
- Macro: UART_RX_MONITOR_BREAK_EN.
- Defined:
  - Adds output break_det (1 bit, reset 0).
  - A frame with all data bits 0 and ferr = 1 is not pushed; instead break_det pulses high for exactly one cycle and err_cnt increments.
- Undefined: break_det is absent; such a frame is pushed as data 0 with ferr = 1.

Test Plan:
- Byte 8N1: defaults, drive 0x55 at 434 cycles/bit, m_ready = 1 -> one pop with m_data = 0x55, perr = 0, ferr = 0; frame_cnt = 1.
- Parity error: PARITY = 2, send 0xA3 with parity bit 1 (correct value 0) -> m_data = 0xA3, m_perr = 1; err_cnt = 1.
- Framing error: stop bit held 0 for one bit time, then line high -> m_ferr = 1. No second frame is decoded until a new falling edge.
- Overflow: m_ready = 0, send 17 bytes 0x00..0x10 -> 16 entries hold 0x00..0x0F, overflow = 1, frame_cnt = 16. Popping all 16 returns them in order; clr_status -> overflow = 0, counters = 0.
- Glitch / reset: a 100-cycle low pulse yields no push and busy returns to 0. RESET_N low mid-DATA of 0x3C -> FIFO empty, busy = 0, next byte 0x81 decoded correctly.
- Break (macro defined): line low for 12 bit times -> break_det high for exactly 1 cycle, m_valid stays 0, err_cnt = 1.
